// File: rtl/stream_filter_pkg.sv
// Shared types and timing constants for the stream filter front end.
// The settle length must match the delay_mem configuration pipeline depth.
package stream_filter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CFG,
      SETTLE,
      STREAM,
      FLUSH
   } state_t;

   localparam int CFG_SETTLE_CYCLES = 2;

endpackage

// File: rtl/raster_counter.sv
// Column/row position tracker with wrap and row/frame boundary decode.
// Shared by real pixels and pad beats so both follow the same column pattern.
module raster_counter #(
   parameter int CW = 16,
   parameter int RW = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_clr,
   input  logic          i_adv,
   input  logic [CW-1:0] i_cols,
   input  logic [RW-1:0] i_rows,
   output logic          o_sol,
   output logic          o_eol,
   output logic          o_sof,
   output logic          o_eof
);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic          w_last_row;

   assign o_sol      = (r_col == '0);
   assign o_eol      = (r_col == i_cols - CW'(1));
   assign w_last_row = (r_row == i_rows - RW'(1));
   assign o_sof      = o_sol && (r_row == '0);
   assign o_eof      = o_eol && w_last_row;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_clr) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_adv) begin
         if (o_eol) begin
            r_col <= '0;
            r_row <= w_last_row ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

endmodule

// File: rtl/line_feeder.sv
// Upstream writer for the delay_mem row-buffer chain: programs row length,
// forwards pixels with row/frame tags, then pads each frame so the lines drain.
//
// state  | meaning
// IDLE   | unconfigured or rejected config, input stalled
// CFG    | issue dn_cfg_set/dn_cfg_delay to the delay memories
// SETTLE | wait out the delay_mem configuration pipeline
// STREAM | accept pixels, forward with one cycle latency
// FLUSH  | emit zero pad beats back-to-back, input stalled
module line_feeder
   import stream_filter_pkg::*;
#(
   parameter int IMG_WIDTH  = 8,
   parameter int MEM_AWIDTH = 16,
   parameter int ROW_AWIDTH = 16,
   parameter int FLUSH_ROWS = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [MEM_AWIDTH-1:0] i_cfg_cols,
   input  logic [ROW_AWIDTH-1:0] i_cfg_rows,
   input  logic                  i_cfg_set,
   output logic                  o_cfg_busy,
   input  logic [IMG_WIDTH-1:0]  i_up_data,
   input  logic                  i_up_val,
   output logic                  o_up_rdy,
   output logic [IMG_WIDTH-1:0]  o_dn_data,
   output logic                  o_dn_val,
   output logic [MEM_AWIDTH-1:0] o_dn_cfg_delay,
   output logic                  o_dn_cfg_set,
   output logic                  o_dn_sol,
   output logic                  o_dn_eol,
   output logic                  o_dn_sof,
   output logic                  o_dn_eof,
   output logic                  o_dn_pad
);

   localparam int FW = ROW_AWIDTH + MEM_AWIDTH;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [MEM_AWIDTH-1:0] r_cols;
   logic [ROW_AWIDTH-1:0] r_rows;
   logic [1:0]            r_settle;
   logic [FW-1:0]         r_flush;

   logic w_cfg_ok;
   logic w_xfer;
   logic w_pad;
   logic w_pad_last;
   logic w_frame_end;
   logic w_sol;
   logic w_eol;
   logic w_sof;
   logic w_eof;

   // A cfg_set in the same cycle overrides any beat, so aborts take effect at once.
   assign w_cfg_ok    = i_cfg_set && (i_cfg_cols != '0) && (i_cfg_rows != '0);
   assign w_xfer      = (r_state == STREAM) && i_up_val && !i_cfg_set;
   assign w_pad       = (r_state == FLUSH) && !i_cfg_set;
   assign w_pad_last  = w_pad && (r_flush == FW'(1));
   assign w_frame_end = w_xfer && w_eof;

   raster_counter #(
      .CW (MEM_AWIDTH),
      .RW (ROW_AWIDTH)
   ) u_raster (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (i_cfg_set || w_pad_last),
      .i_adv   (w_xfer || w_pad),
      .i_cols  (r_cols),
      .i_rows  (r_rows),
      .o_sol   (w_sol),
      .o_eol   (w_eol),
      .o_sof   (w_sof),
      .o_eof   (w_eof)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_up_rdy    = 1'b0;
      o_cfg_busy  = (r_state != IDLE);
      unique case (r_state)
         IDLE:    w_state_nxt = IDLE;
         CFG:     w_state_nxt = SETTLE;
         SETTLE:  if (r_settle == '0) w_state_nxt = STREAM;
         STREAM: begin
            o_up_rdy = 1'b1;
            if (w_frame_end) w_state_nxt = (FLUSH_ROWS == 0) ? STREAM : FLUSH;
         end
         FLUSH:   if (w_pad_last) w_state_nxt = STREAM;
         default: w_state_nxt = IDLE;
      endcase
      if (i_cfg_set) w_state_nxt = w_cfg_ok ? CFG : IDLE;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cols         <= '0;
         r_rows         <= '0;
         r_settle       <= '0;
         r_flush        <= '0;
         o_dn_cfg_set   <= 1'b0;
         o_dn_cfg_delay <= '0;
         o_dn_val       <= 1'b0;
         o_dn_data      <= '0;
         o_dn_sol       <= 1'b0;
         o_dn_eol       <= 1'b0;
         o_dn_sof       <= 1'b0;
         o_dn_eof       <= 1'b0;
         o_dn_pad       <= 1'b0;
      end else begin
         if (w_cfg_ok) begin
            r_cols <= i_cfg_cols;
            r_rows <= i_cfg_rows;
         end

         if (r_state == CFG)                          r_settle <= 2'(CFG_SETTLE_CYCLES - 1);
         else if (r_state == SETTLE && r_settle != '0) r_settle <= r_settle - 2'd1;

         // Flush length is a multiple of the row length, so col ends back at 0.
         if (i_cfg_set)        r_flush <= '0;
         else if (w_frame_end) r_flush <= FW'(FLUSH_ROWS) * FW'(r_cols);
         else if (w_pad)       r_flush <= r_flush - FW'(1);

         o_dn_cfg_set <= (r_state == CFG) && !i_cfg_set;
         if (r_state == CFG) o_dn_cfg_delay <= r_cols;

         o_dn_val  <= w_xfer || w_pad;
         o_dn_data <= w_xfer ? i_up_data : '0;
         o_dn_sol  <= (w_xfer || w_pad) && w_sol;
         o_dn_eol  <= (w_xfer || w_pad) && w_eol;
         o_dn_sof  <= w_xfer && w_sof;
         o_dn_eof  <= w_xfer && w_eof;
         o_dn_pad  <= w_pad;
      end
   end

endmodule

// File: tb/tb_line_feeder.sv
// Directed bench for line_feeder: expected beats are queued as stimulus is
// driven and compared against the downstream stream on every falling edge.
module tb_line_feeder;

   localparam int IW = 8;
   localparam int CW = 16;
   localparam int RW = 16;
   localparam int FR = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CW-1:0] cfg_cols;
   logic [RW-1:0] cfg_rows;
   logic          cfg_set;
   logic [IW-1:0] up_data;
   logic          up_val;
   logic          cfg_busy;
   logic          up_rdy;
   logic [IW-1:0] dn_data;
   logic          dn_val;
   logic [CW-1:0] dn_cfg_delay;
   logic          dn_cfg_set;
   logic          dn_sol;
   logic          dn_eol;
   logic          dn_sof;
   logic          dn_eof;
   logic          dn_pad;

   int checks = 0;
   int errors = 0;
   logic [12:0] sb_q[$];
   logic [12:0] mon_e;

   line_feeder #(
      .IMG_WIDTH  (IW),
      .MEM_AWIDTH (CW),
      .ROW_AWIDTH (RW),
      .FLUSH_ROWS (FR)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_cfg_cols     (cfg_cols),
      .i_cfg_rows     (cfg_rows),
      .i_cfg_set      (cfg_set),
      .o_cfg_busy     (cfg_busy),
      .i_up_data      (up_data),
      .i_up_val       (up_val),
      .o_up_rdy       (up_rdy),
      .o_dn_data      (dn_data),
      .o_dn_val       (dn_val),
      .o_dn_cfg_delay (dn_cfg_delay),
      .o_dn_cfg_set   (dn_cfg_set),
      .o_dn_sol       (dn_sol),
      .o_dn_eol       (dn_eol),
      .o_dn_sof       (dn_sof),
      .o_dn_eof       (dn_eof),
      .o_dn_pad       (dn_pad)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input logic [IW-1:0] d, input logic sol, input logic eol,
                            input logic sof, input logic eof, input logic pad);
      sb_q.push_back({d, sol, eol, sof, eof, pad});
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ctl"}, 32'({cfg_busy, up_rdy, dn_val, dn_cfg_set,
                              dn_sol, dn_eol, dn_sof, dn_eof, dn_pad}), 32'(0));
      chk({tag, "_data"}, 32'({dn_data, dn_cfg_delay}), 32'(0));
   endtask

   always @(negedge clk) begin
      if (dn_val === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_beat", 32'(dn_val), 32'(0));
         end else begin
            mon_e = sb_q.pop_front();
            chk("beat", 32'({dn_data, dn_sol, dn_eol, dn_sof, dn_eof, dn_pad}), 32'(mon_e));
         end
      end else begin
         chk("idle_flags", 32'({dn_val, dn_sol, dn_eol, dn_sof, dn_eof, dn_pad}), 32'(0));
      end
   end

   task automatic drain();
      for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'(0));
   endtask

   // Starts the cfg_set pulse in the current cycle (T).
   task automatic do_cfg(input int cols, input int rows);
      bit ok;
      ok       = (cols != 0) && (rows != 0);
      cfg_cols = CW'(cols);
      cfg_rows = RW'(rows);
      cfg_set  = 1'b1;
      @(negedge clk);
      chk("cfg_set_T", 32'(dn_cfg_set), 32'(0));
      cyc();
      cfg_set  = 1'b0;
      cfg_cols = '1;
      cfg_rows = '1;
      if (ok) begin
         @(negedge clk);
         chk("cfg_set_T1", 32'(dn_cfg_set), 32'(0));
         chk("dn_val_T1", 32'(dn_val), 32'(0));
         cyc();
         @(negedge clk);
         chk("cfg_set_T2", 32'(dn_cfg_set), 32'(1));
         chk("cfg_delay_T2", 32'(dn_cfg_delay), 32'(cols));
         chk("busy_T2", 32'(cfg_busy), 32'(1));
         chk("up_rdy_T2", 32'(up_rdy), 32'(0));
         cyc();
         @(negedge clk);
         chk("cfg_set_T3", 32'(dn_cfg_set), 32'(0));
         chk("up_rdy_T3", 32'(up_rdy), 32'(0));
         chk("dn_val_T3", 32'(dn_val), 32'(0));
         cyc();
         chk("up_rdy_T4", 32'(up_rdy), 32'(1));
      end else begin
         repeat (4) begin
            @(negedge clk);
            chk("bad_cfg_busy", 32'(cfg_busy), 32'(0));
            chk("bad_cfg_rdy", 32'(up_rdy), 32'(0));
            chk("bad_cfg_set", 32'(dn_cfg_set), 32'(0));
            cyc();
         end
      end
   endtask

   // Streams one frame; abort_at >= 0 returns during flush after that many pads.
   task automatic run_frame(input int cols, input int rows, input int gap_pct,
                            input int base, input int abort_at);
      int col;
      int n;
      int total;
      int npad;
      col   = 0;
      n     = 0;
      total = cols * rows;
      while (n < total) begin
         chk("up_rdy_stream", 32'(up_rdy), 32'(1));
         if (int'($urandom_range(99)) < gap_pct) begin
            up_val  = 1'b0;
            up_data = IW'($urandom);
         end else begin
            up_val  = 1'b1;
            up_data = IW'(base + n + 1);
            push_beat(IW'(base + n + 1), col == 0, col == cols - 1,
                      n == 0, n == total - 1, 1'b0);
            col = (col == cols - 1) ? 0 : col + 1;
            n++;
         end
         cyc();
      end
      up_val = 1'b0;
      npad   = (abort_at >= 0) ? abort_at : FR * cols;
      for (int k = 0; k < npad; k++)
         push_beat('0, (k % cols) == 0, (k % cols) == cols - 1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < npad; k++) begin
         chk("up_rdy_flush", 32'(up_rdy), 32'(0));
         cyc();
      end
      if (abort_at < 0) begin
         chk("up_rdy_after_flush", 32'(up_rdy), 32'(1));
         drain();
         cyc();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n    = 1'b1;
      cfg_cols = '0;
      cfg_rows = '0;
      cfg_set  = 1'b0;
      up_data  = '0;
      up_val   = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_quiet("reset");
      end
      cyc();
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk_quiet("idle");
      end
      cyc();

      do_cfg(4, 2);
      run_frame(4, 2, 0, 0, -1);
      run_frame(4, 2, 35, 16, -1);

      run_frame(4, 2, 0, 32, 3);
      do_cfg(3, 2);
      run_frame(3, 2, 20, 64, -1);

      do_cfg(0, 2);
      do_cfg(1, 1);
      run_frame(1, 1, 0, 100, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/line_feeder.md
Name: line_feeder

Overview:
- Upstream writer for the delay_mem row-buffer chain that feeds the stream filter.
- Accepts a pixel stream with a valid/ready handshake from the host side.
- Programs the downstream delay memories with the row length, then forwards pixels as the up_val-style strobe stream those memories consume. It tags row and frame boundaries.
- After each frame it appends zero "pad" pixels so the delay lines drain. Delay memories advance only on valid, so without padding the last rows would stay trapped.

Parameters:
- IMG_WIDTH, 8, pixel width in bits.
- MEM_AWIDTH, 16, width of the column count; matches the delay_mem address width.
- ROW_AWIDTH, 16, width of the row count.
- FLUSH_ROWS, 2, rows of pad pixels appended per frame (kernel height minus 1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cfg_cols  in  MEM_AWIDTH  pixels per row.
- cfg_rows  in  ROW_AWIDTH  rows per frame.
- cfg_set  in  1  one-cycle pulse; latches cfg_cols and cfg_rows and starts configuration.
- cfg_busy  out  1  high whenever the state is not IDLE.
- up_data  in  IMG_WIDTH  input pixel.
- up_val  in  1  input pixel valid.
- up_rdy  out  1  input ready.
- dn_data  out  IMG_WIDTH  output pixel; 0 during pad.
- dn_val  out  1  output strobe; drives delay_mem up_val.
- dn_cfg_delay  out  MEM_AWIDTH  delay value for the delay memories.
- dn_cfg_set  out  1  one-cycle configuration pulse to the delay memories.
- dn_sol  out  1  first pixel of a row; qualified by dn_val.
- dn_eol  out  1  last pixel of a row; qualified by dn_val.
- dn_sof  out  1  first pixel of a frame; qualified by dn_val.
- dn_eof  out  1  last real pixel of a frame; qualified by dn_val.
- dn_pad  out  1  current beat is a pad pixel; qualified by dn_val.

Behaviour:

Reset (rst low, asynchronous):
- State goes to IDLE.
- All outputs go to 0: up_rdy, dn_val, dn_cfg_set, all flags, dn_data, dn_cfg_delay, cfg_busy.
- Column, row and flush counters clear.

Configuration and states:
- cfg_set is honoured in any state; it aborts any frame in progress and enters CFG.
- If cfg_set arrives with cfg_cols==0 or cfg_rows==0, the block goes to IDLE instead and issues no dn_cfg_set.
- IDLE: up_rdy=0. Leaves only on a valid cfg_set.
- CFG (1 cycle): registers dn_cfg_delay=cfg_cols and dn_cfg_set=1 for exactly one cycle, then goes to SETTLE.
- SETTLE (2 cycles): covers the delay_mem cfg pipeline. up_rdy=0 and dn_val=0. Then goes to STREAM.
- STREAM:
  - up_rdy=1.
  - A transfer occurs on up_val & up_rdy.
  - Each transfer registers dn_data=up_data and dn_val=1 on the next edge, so latency is 1 cycle.
  - No transfer means dn_val=0 on the next cycle; bubbles pass through unchanged.
  - col advances 0..cfg_cols-1, then wraps to 0 and row increments.
  - On the transfer with row==cfg_rows-1 and col==cfg_cols-1: dn_eof=1 and the state goes to FLUSH. up_rdy falls in the same cycle the FLUSH state is entered.
- FLUSH:
  - up_rdy=0.
  - Emits one pad beat per cycle with no gaps: dn_val=1, dn_data=0, dn_pad=1.
  - Emits exactly FLUSH_ROWS*cfg_cols beats.
  - The flush counter is ROW_AWIDTH+MEM_AWIDTH bits wide; it must not overflow.
  - dn_sol and dn_eol follow the same column pattern as real rows.
  - After the last pad beat, the state goes back to STREAM with counters cleared for the next frame. No reconfiguration occurs.
  - If FLUSH_ROWS==0, FLUSH is skipped and the state goes directly to STREAM.

Flags:
- dn_sol = (col==0).
- dn_eol = (col==cfg_cols-1).
- dn_sof = (row==0 && col==0) on a real pixel.
- When cfg_cols==1, dn_sol and dn_eol are asserted together on every beat.
- All flags are 0 when dn_val=0.

Other rules:
- Counter compare values are the latched configuration values. Changing cfg_cols or cfg_rows without cfg_set has no effect.
- cfg_set during FLUSH or STREAM discards the remaining pad and pixels. dn_val=0 from the next cycle until STREAM is re-entered.
- cfg_busy = (state != IDLE).

Decomposition:
- Package stream_filter_pkg holds:
  - the state enum: IDLE, CFG, SETTLE, STREAM, FLUSH;
  - the constant CFG_SETTLE_CYCLES = 2, shared with delay_mem timing.
- One natural sub-module: raster_counter. It provides col/row counters with wrap, sol/eol/sof/eof decode and an advance enable. It is reused for both stream and flush beats.

Test Plan:
1. Reset and idle: hold rst low 3 cycles and release with no cfg_set. All outputs stay 0 and up_rdy stays 0 indefinitely.
2. Configuration sequence: cfg_cols=4, cfg_rows=2, cfg_set pulse at cycle T.
   - dn_cfg_set=1 only at T+2 (CFG state registered), with dn_cfg_delay=4.
   - up_rdy first rises at T+4.
3. Full frame with up_val held high: 8 pixels with values 1..8.
   - dn_data 1..8 on consecutive cycles.
   - dn_sol on pixels 1 and 5; dn_eol on pixels 4 and 8; dn_sof on pixel 1; dn_eof on pixel 8.
   - Then 8 pad beats (FLUSH_ROWS=2): dn_data=0, dn_pad=1, with dn_eol on pad beats 4 and 8.
   - up_rdy=0 throughout the flush, then returns to 1.
4. Random up_val gaps in the same frame: dn_val mirrors the accepted transfers delayed by 1 cycle, and the flag positions are unchanged.
5. Abort: cfg_set with cfg_cols=3 mid-flush.
   - Pad beats stop the next cycle.
   - A new dn_cfg_set arrives with dn_cfg_delay=3.
   - The next frame's rows are 3 pixels long.
6. Degenerate settings:
   - cfg_cols=0: no dn_cfg_set, and the block stays in IDLE.
   - cfg_cols=1, cfg_rows=1: a single pixel carries dn_sol, dn_eol, dn_sof and dn_eof together, followed by 2 pad beats each with dn_sol and dn_eol set.
